pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS32 pipeline of each core.
- Drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC hold.
- Registers use hold-on-stall and clear-on-flush semantics; flush is ignored while stalled.
- Sequences load-use and branch-operand hazards, multi-cycle mul/div occupancy of EX, and the shared-memory request/ack wait in MEM; keeps stall/flush performance counters.

Parameters:
- MULDIV_LAT, 4, total cycles a mul/div instruction occupies EX; must be >= 1.
- DELAY_SLOT, 1, if 1 a taken branch/jump does not flush IF/ID (MIPS delay slot); if 0 it does.

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID
- ID_UsesRs, ID_UsesRt  in  1 each  ID instruction reads Rs / Rt
- ID_IsBranch  in  1  ID holds a branch resolved in ID
- BranchTaken  in  1  branch/jump redirect computed in ID this cycle
- EX_MemRead, EX_RegWrite  in  1 each  EX instruction is a load / writes a register
- EX_Rd  in  5  EX destination register
- MulDiv_Start  in  1  EX holds a mul/div instruction
- MEM_MemRead  in  1  MEM instruction is a load
- MEM_Rd  in  5  MEM destination register
- MEM_Req  in  1  MEM stage has a shared-memory access outstanding
- MEM_Ack  in  1  arbiter grants/completes the access this cycle
- Stall_PC, Stall_IFID, Stall_IDEX, Stall_EXMEM, Stall_MEMWB  out  1 each  hold the respective register
- Flush_IFID, Flush_IDEX, Flush_EXMEM, Flush_MEMWB  out  1 each  load a bubble into the respective register
- StallCount  out  32  cycles with Stall_PC=1
- FlushCount  out  32  cycles with any Flush_* = 1

Behaviour:
- State machine: RUN, MD_BUSY. Registers: state, cnt[$clog2(MULDIV_LAT+1)-1:0], StallCount, FlushCount.
- Reset: state=RUN, cnt=0, both counters=0. All stall/flush outputs are combinational and are 0 whenever state=RUN and hazard inputs are 0.
- Reset mid-operation: aborts MD_BUSY and returns to RUN the next cycle.
- Hazard terms:
  - match(R) = R!=0 && ((ID_UsesRs && ID_Rs==R) || (ID_UsesRt && ID_Rt==R)).
  - mem_wait = MEM_Req && !MEM_Ack.
  - md_stall = (state==RUN && MulDiv_Start && MULDIV_LAT>1 && !mem_wait) || (state==MD_BUSY && cnt!=0).
  - md_hold = md_stall || (state==MD_BUSY && mem_wait).
  - load_use = EX_MemRead && match(EX_Rd).
  - br_haz = ID_IsBranch && ((EX_RegWrite && match(EX_Rd)) || (MEM_MemRead && match(MEM_Rd))).
  - id_stall = load_use || br_haz.
- Output priority, highest first:
  1. mem_wait: Stall_PC/IFID/IDEX/EXMEM=1, Flush_MEMWB=1, all others 0.
  2. md_stall: Stall_PC/IFID/IDEX=1, Flush_EXMEM=1, all others 0.
  3. id_stall: Stall_PC/IFID=1, Flush_IDEX=1, all others 0.
  4. BranchTaken && DELAY_SLOT==0: Flush_IFID=1, all others 0.
  5. Otherwise all 0.
- BranchTaken is ignored whenever any stall is active (branch not yet resolved or ID frozen).
- Invariant: Flush_X and Stall_X are never both 1.
- Mul/div sequencing:
  - RUN && MulDiv_Start && !mem_wait && MULDIV_LAT>1: load cnt=MULDIV_LAT-2, go MD_BUSY.
  - MD_BUSY: cnt decrements each cycle while cnt!=0, including during mem_wait.
  - MD_BUSY with cnt==0 && !mem_wait: release cycle; no md stall, go RUN. The EX instruction advances this cycle; no retrigger because state≠RUN.
  - Net effect: EX occupied exactly MULDIV_LAT cycles absent memory stalls; stall asserted MULDIV_LAT-1 cycles.
  - MULDIV_LAT==1: never leaves RUN, no stall.
  - MulDiv_Start during mem_wait in RUN: entry deferred until mem_wait clears.
- Memory handshake: MEM_Req held by MEM until the MEM_Ack pulse. The stall covers every cycle of Req without Ack; the Ack cycle itself is unstalled.
- Counters: StallCount += 1 when Stall_PC; FlushCount += 1 when any Flush_*. Both wrap modulo 2^32.

Test Plan:
- Load-use: EX_MemRead=1, EX_Rd=5, ID_Rs=5, ID_UsesRs=1 -> exactly 1 cycle Stall_PC=Stall_IFID=Flush_IDEX=1; StallCount=1.
- Zero register: EX_MemRead=1, EX_Rd=0, ID_Rs=0, ID_UsesRs=1 -> no stall, all outputs 0.
- Mul/div with MULDIV_LAT=4: MulDiv_Start held until EX advances -> Stall_IDEX/Flush_EXMEM high 3 consecutive cycles then 0, state back to RUN. Repeat with Reset asserted in the 2nd stall cycle -> outputs 0 the next cycle, state=RUN.
- Memory wait: MEM_Req=1, MEM_Ack at cycle 3 -> Stall_EXMEM=Flush_MEMWB=1 for cycles 0-2, 0 at cycle 3. Concurrent load_use -> only memory-wait outputs, Flush_IDEX=0.
- Branch: ID_IsBranch=1, ID_Rt=7, ID_UsesRt=1, EX_RegWrite=1, EX_Rd=7, BranchTaken=1, DELAY_SLOT=0 -> cycle 1: stall, Flush_IFID=0. Next cycle, no hazard -> Flush_IFID=1, FlushCount increments once per flush cycle. With DELAY_SLOT=1 -> Flush_IFID never asserted.
- Mul/div overlapping memory: MEM_Req held 5 cycles during MD_BUSY, MULDIV_LAT=3 -> cnt reaches 0, release deferred until Ack cycle, then RUN.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use and branch-operand
// interlocks, multi-cycle mul/div occupancy of EX, shared-memory wait in MEM, perf counters.
module pipe_hazard_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter int DELAY_SLOT = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        ID_IsBranch,
  input  logic        BranchTaken,
  input  logic        EX_MemRead,
  input  logic        EX_RegWrite,
  input  logic [4:0]  EX_Rd,
  input  logic        MulDiv_Start,
  input  logic        MEM_MemRead,
  input  logic [4:0]  MEM_Rd,
  input  logic        MEM_Req,
  input  logic        MEM_Ack,
  output logic        Stall_PC,
  output logic        Stall_IFID,
  output logic        Stall_IDEX,
  output logic        Stall_EXMEM,
  output logic        Stall_MEMWB,
  output logic        Flush_IFID,
  output logic        Flush_IDEX,
  output logic        Flush_EXMEM,
  output logic        Flush_MEMWB,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
);

  localparam int CW = $clog2(MULDIV_LAT + 1);
  localparam logic MD_MULTI = (MULDIV_LAT > 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'((MULDIV_LAT > 1) ? (MULDIV_LAT - 2) : 0);

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;

  logic match_ex, match_mem;
  logic mem_wait, md_stall, md_hold, load_use, br_haz, id_stall, any_flush;

  // R0 is hardwired to zero, so it never creates a dependency.
  assign match_ex  = (EX_Rd != 5'd0) &&
                     ((ID_UsesRs && ID_Rs == EX_Rd) || (ID_UsesRt && ID_Rt == EX_Rd));
  assign match_mem = (MEM_Rd != 5'd0) &&
                     ((ID_UsesRs && ID_Rs == MEM_Rd) || (ID_UsesRt && ID_Rt == MEM_Rd));

  assign mem_wait = MEM_Req && !MEM_Ack;
  assign md_stall = (state == RUN && MulDiv_Start && MD_MULTI && !mem_wait) ||
                    (state == MD_BUSY && cnt != '0);
  assign md_hold  = md_stall || (state == MD_BUSY && mem_wait);
  assign load_use = EX_MemRead && match_ex;
  assign br_haz   = ID_IsBranch && ((EX_RegWrite && match_ex) || (MEM_MemRead && match_mem));
  assign id_stall = load_use || br_haz;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= RUN;
      cnt        <= '0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (Stall_PC)
        StallCount <= StallCount + 32'd1;
      if (any_flush)
        FlushCount <= FlushCount + 32'd1;
    end
  end

  // The counter keeps draining during a memory wait; release waits for the wait to clear.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RUN: begin
        if (MulDiv_Start && MD_MULTI && !mem_wait) begin
          state_next = MD_BUSY;
          cnt_next   = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt != '0)
          cnt_next = cnt - CW'(1);
        if (!md_hold)
          state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // A stalled ID stage has not resolved its branch, so redirects only act when nothing stalls.
  always_comb begin
    Stall_PC    = 1'b0;
    Stall_IFID  = 1'b0;
    Stall_IDEX  = 1'b0;
    Stall_EXMEM = 1'b0;
    Stall_MEMWB = 1'b0;
    Flush_IFID  = 1'b0;
    Flush_IDEX  = 1'b0;
    Flush_EXMEM = 1'b0;
    Flush_MEMWB = 1'b0;
    if (mem_wait) begin
      Stall_PC    = 1'b1;
      Stall_IFID  = 1'b1;
      Stall_IDEX  = 1'b1;
      Stall_EXMEM = 1'b1;
      Flush_MEMWB = 1'b1;
    end else if (md_stall) begin
      Stall_PC    = 1'b1;
      Stall_IFID  = 1'b1;
      Stall_IDEX  = 1'b1;
      Flush_EXMEM = 1'b1;
    end else if (id_stall) begin
      Stall_PC    = 1'b1;
      Stall_IFID  = 1'b1;
      Flush_IDEX  = 1'b1;
    end else if (BranchTaken && DELAY_SLOT == 0) begin
      Flush_IFID  = 1'b1;
    end
  end

  assign any_flush = Flush_IFID || Flush_IDEX || Flush_EXMEM || Flush_MEMWB;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances (LAT=4/DS=0, LAT=4/DS=1, LAT=3/DS=0)
// share stimulus; outputs are packed {Stall PC,IFID,IDEX,EXMEM,MEMWB, Flush IFID,IDEX,EXMEM,MEMWB}.
module tb_pipe_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] ID_Rs, ID_Rt, EX_Rd, MEM_Rd;
  logic       ID_UsesRs, ID_UsesRt, ID_IsBranch, BranchTaken;
  logic       EX_MemRead, EX_RegWrite, MulDiv_Start, MEM_MemRead, MEM_Req, MEM_Ack;

  logic [8:0]  outA, outB, outC;
  logic [31:0] stallA, flushA, stallB, flushB, stallC, flushC;

  localparam logic [8:0] IDLE = 9'b00000_0000;
  localparam logic [8:0] MEMW = 9'b11110_0001;
  localparam logic [8:0] MD   = 9'b11100_0010;
  localparam logic [8:0] IDS  = 9'b11000_0100;
  localparam logic [8:0] BR   = 9'b00000_1000;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  pipe_hazard_ctrl #(.MULDIV_LAT(4), .DELAY_SLOT(0)) dutA (
    .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs),
    .ID_UsesRt(ID_UsesRt), .ID_IsBranch(ID_IsBranch), .BranchTaken(BranchTaken),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_Rd(EX_Rd),
    .MulDiv_Start(MulDiv_Start), .MEM_MemRead(MEM_MemRead), .MEM_Rd(MEM_Rd),
    .MEM_Req(MEM_Req), .MEM_Ack(MEM_Ack),
    .Stall_PC(outA[8]), .Stall_IFID(outA[7]), .Stall_IDEX(outA[6]), .Stall_EXMEM(outA[5]),
    .Stall_MEMWB(outA[4]), .Flush_IFID(outA[3]), .Flush_IDEX(outA[2]),
    .Flush_EXMEM(outA[1]), .Flush_MEMWB(outA[0]),
    .StallCount(stallA), .FlushCount(flushA));

  pipe_hazard_ctrl #(.MULDIV_LAT(4), .DELAY_SLOT(1)) dutB (
    .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs),
    .ID_UsesRt(ID_UsesRt), .ID_IsBranch(ID_IsBranch), .BranchTaken(BranchTaken),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_Rd(EX_Rd),
    .MulDiv_Start(MulDiv_Start), .MEM_MemRead(MEM_MemRead), .MEM_Rd(MEM_Rd),
    .MEM_Req(MEM_Req), .MEM_Ack(MEM_Ack),
    .Stall_PC(outB[8]), .Stall_IFID(outB[7]), .Stall_IDEX(outB[6]), .Stall_EXMEM(outB[5]),
    .Stall_MEMWB(outB[4]), .Flush_IFID(outB[3]), .Flush_IDEX(outB[2]),
    .Flush_EXMEM(outB[1]), .Flush_MEMWB(outB[0]),
    .StallCount(stallB), .FlushCount(flushB));

  pipe_hazard_ctrl #(.MULDIV_LAT(3), .DELAY_SLOT(0)) dutC (
    .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs),
    .ID_UsesRt(ID_UsesRt), .ID_IsBranch(ID_IsBranch), .BranchTaken(BranchTaken),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_Rd(EX_Rd),
    .MulDiv_Start(MulDiv_Start), .MEM_MemRead(MEM_MemRead), .MEM_Rd(MEM_Rd),
    .MEM_Req(MEM_Req), .MEM_Ack(MEM_Ack),
    .Stall_PC(outC[8]), .Stall_IFID(outC[7]), .Stall_IDEX(outC[6]), .Stall_EXMEM(outC[5]),
    .Stall_MEMWB(outC[4]), .Flush_IFID(outC[3]), .Flush_IDEX(outC[2]),
    .Flush_EXMEM(outC[1]), .Flush_MEMWB(outC[0]),
    .StallCount(stallC), .FlushCount(flushC));

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
    ID_IsBranch = 1'b0; BranchTaken = 1'b0; EX_MemRead = 1'b0; EX_RegWrite = 1'b0;
    EX_Rd = 5'd0; MulDiv_Start = 1'b0; MEM_MemRead = 1'b0; MEM_Rd = 5'd0;
    MEM_Req = 1'b0; MEM_Ack = 1'b0;
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 3 units later.
  task automatic nextCycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic doReset();
    Reset = 1'b1;
    applyStimulus();
    nextCycle();
    nextCycle();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    applyStimulus();
    doReset();

    // Reset state
    settle();
    checkOutput("reset_out", 32'(outA), 32'(IDLE));
    checkOutput("reset_stallcnt", stallA, 32'd0);
    checkOutput("reset_flushcnt", flushA, 32'd0);

    // Load-use: one bubble cycle
    EX_MemRead = 1'b1; EX_Rd = 5'd5; ID_Rs = 5'd5; ID_UsesRs = 1'b1;
    settle();
    checkOutput("loaduse_c0", 32'(outA), 32'(IDS));
    nextCycle();
    applyStimulus();
    settle();
    checkOutput("loaduse_c1", 32'(outA), 32'(IDLE));
    checkOutput("loaduse_stallcnt", stallA, 32'd1);
    checkOutput("loaduse_flushcnt", flushA, 32'd1);

    // Register zero and unused-operand cases
    EX_MemRead = 1'b1; EX_Rd = 5'd0; ID_Rs = 5'd0; ID_UsesRs = 1'b1;
    settle();
    checkOutput("zero_reg", 32'(outA), 32'(IDLE));
    EX_Rd = 5'd5; ID_Rs = 5'd3; ID_Rt = 5'd5; ID_UsesRt = 1'b0;
    settle();
    checkOutput("rt_unused", 32'(outA), 32'(IDLE));
    ID_UsesRt = 1'b1;
    settle();
    checkOutput("rt_used", 32'(outA), 32'(IDS));
    applyStimulus();
    nextCycle();

    // Mul/div LAT=4: three stall cycles then release
    doReset();
    MulDiv_Start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checkOutput($sformatf("md4_stall%0d", i), 32'(outA), 32'(MD));
      nextCycle();
    end
    settle();
    checkOutput("md4_release", 32'(outA), 32'(IDLE));
    nextCycle();
    MulDiv_Start = 1'b0;
    settle();
    checkOutput("md4_after", 32'(outA), 32'(IDLE));
    checkOutput("md4_stallcnt", stallA, 32'd3);
    checkOutput("md4_flushcnt", flushA, 32'd3);

    // Mul/div aborted by reset in its second stall cycle
    nextCycle();
    MulDiv_Start = 1'b1;
    settle();
    checkOutput("mdrst_c0", 32'(outA), 32'(MD));
    nextCycle();
    Reset = 1'b1;
    settle();
    checkOutput("mdrst_c1", 32'(outA), 32'(MD));
    nextCycle();
    Reset = 1'b0;
    MulDiv_Start = 1'b0;
    settle();
    checkOutput("mdrst_after", 32'(outA), 32'(IDLE));
    checkOutput("mdrst_stallcnt", stallA, 32'd0);

    // Memory wait: Ack in cycle 3
    doReset();
    MEM_Req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checkOutput($sformatf("memw_c%0d", i), 32'(outA), 32'(MEMW));
      nextCycle();
    end
    MEM_Ack = 1'b1;
    settle();
    checkOutput("memw_ack", 32'(outA), 32'(IDLE));
    nextCycle();
    MEM_Ack = 1'b0;
    EX_MemRead = 1'b1; EX_Rd = 5'd9; ID_Rt = 5'd9; ID_UsesRt = 1'b1;
    settle();
    checkOutput("memw_cnts", stallA, 32'd3);
    checkOutput("memw_over_loaduse", 32'(outA), 32'(MEMW));
    nextCycle();
    MEM_Ack = 1'b1;
    settle();
    checkOutput("memw_ack_loaduse", 32'(outA), 32'(IDS));
    nextCycle();
    applyStimulus();
    settle();
    checkOutput("memw_stallcnt", stallA, 32'd5);

    // Branch operand hazard then taken redirect
    doReset();
    ID_IsBranch = 1'b1; ID_Rt = 5'd7; ID_UsesRt = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 5'd7;
    BranchTaken = 1'b1;
    settle();
    checkOutput("br_haz_ds0", 32'(outA), 32'(IDS));
    checkOutput("br_haz_ds1", 32'(outB), 32'(IDS));
    nextCycle();
    EX_RegWrite = 1'b0;
    settle();
    checkOutput("br_taken_ds0", 32'(outA), 32'(BR));
    checkOutput("br_taken_ds1", 32'(outB), 32'(IDLE));
    nextCycle();
    BranchTaken = 1'b0; MEM_MemRead = 1'b1; MEM_Rd = 5'd7;
    settle();
    checkOutput("br_flushcnt_ds0", flushA, 32'd2);
    checkOutput("br_flushcnt_ds1", flushB, 32'd1);
    checkOutput("br_mem_load", 32'(outA), 32'(IDS));
    ID_IsBranch = 1'b0; MEM_MemRead = 1'b0; EX_RegWrite = 1'b1;
    settle();
    checkOutput("nonbr_alu_dep", 32'(outA), 32'(IDLE));
    applyStimulus();
    nextCycle();

    // Mul/div LAT=3 overlapped by a 5-cycle memory wait
    doReset();
    MulDiv_Start = 1'b1;
    settle();
    checkOutput("mdmem_c0", 32'(outC), 32'(MD));
    nextCycle();
    MEM_Req = 1'b1;
    for (int i = 1; i < 5; i++) begin
      settle();
      checkOutput($sformatf("mdmem_c%0d", i), 32'(outC), 32'(MEMW));
      nextCycle();
    end
    MEM_Ack = 1'b1;
    settle();
    checkOutput("mdmem_release", 32'(outC), 32'(IDLE));
    nextCycle();
    MulDiv_Start = 1'b0; MEM_Req = 1'b0; MEM_Ack = 1'b0;
    settle();
    checkOutput("mdmem_run", 32'(outC), 32'(IDLE));
    checkOutput("mdmem_stallcnt", stallC, 32'd5);

    // Mul/div entry deferred while memory waits
    MulDiv_Start = 1'b1; MEM_Req = 1'b1;
    settle();
    checkOutput("defer_c0", 32'(outC), 32'(MEMW));
    nextCycle();
    MEM_Ack = 1'b1;
    settle();
    checkOutput("defer_entry", 32'(outC), 32'(MD));
    nextCycle();
    MEM_Req = 1'b0; MEM_Ack = 1'b0;
    settle();
    checkOutput("defer_busy", 32'(outC), 32'(MD));
    nextCycle();
    settle();
    checkOutput("defer_release", 32'(outC), 32'(IDLE));
    applyStimulus();
    nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
